// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_MACK,
        ST_STOP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_master_seq_qtick.sv
// Quarter-bit tick generator; the count freezes while hold is high so a
// slave stretching SCL lengthens only the phase it is stretching.
module i2c_qtick #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
        end
    end

    assign tick = en && !hold && (cnt == LAST);

endmodule

// File: rtl/i2c_master_seq.sv
// Command-driven I2C master: single-byte register write or N-byte burst read,
// driving open-drain SCL/SDA pad enables.
module i2c_master_seq #(
    parameter int CLK_DIV = 250,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_rw,
    input  logic [7:0]       cmd_wdata,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             done,
    output logic             nack_err,
    output logic             busy,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe,
    output logic             sda_oe
);

    import i2c_pkg::*;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state, next_state;
    phase_t           phase;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] remaining;
    logic             rw_q;
    logic [7:0]       wdata_q;
    logic             sda_sample;

    logic qt_en, hold, tick, sample, bit_end, accept, scl_low;

    assign accept  = cmd_valid && cmd_ready;
    assign qt_en   = (state != ST_IDLE) && (state != ST_DONE);
    assign hold    = (phase == Q2) && !scl_oe && !scl_i;
    assign sample  = tick && (phase == Q2);
    assign bit_end = tick && (phase == Q3);
    assign scl_low = (phase == Q0) || (phase == Q1);

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .en   (qt_en),
        .hold (hold),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= Q0;
        end else if (!qt_en) begin
            phase <= Q0;
        end else if (tick) begin
            phase <= phase_t'(phase + 2'd1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (cmd_valid) next_state = ST_START;
            ST_START: if (bit_end) next_state = ST_ADDR;
            ST_ADDR:  if (bit_end && bit_cnt == 3'd7) next_state = ST_AACK;
            ST_AACK: begin
                if (bit_end) begin
                    if (sda_sample)            next_state = ST_STOP;
                    else if (rw_q == RW_WRITE) next_state = ST_WDATA;
                    else                       next_state = ST_RDATA;
                end
            end
            ST_WDATA: if (bit_end && bit_cnt == 3'd7) next_state = ST_WACK;
            ST_WACK:  if (bit_end) next_state = ST_STOP;
            ST_RDATA: if (bit_end && bit_cnt == 3'd7) next_state = ST_MACK;
            ST_MACK:  if (bit_end) next_state = (remaining > ONE) ? ST_RDATA : ST_STOP;
            ST_STOP:  if (bit_end) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Pad enables are decoded from state and phase so SDA only moves on q0 entry.
    always_comb begin
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_START: begin
                scl_oe = (phase == Q3);
                sda_oe = (phase == Q2) || (phase == Q3);
            end
            ST_ADDR, ST_WDATA: begin
                scl_oe = scl_low;
                sda_oe = !tx_shift[7];
            end
            ST_AACK, ST_WACK, ST_RDATA: scl_oe = scl_low;
            ST_MACK: begin
                scl_oe = scl_low;
                sda_oe = (remaining > ONE);
            end
            ST_STOP: begin
                scl_oe = scl_low;
                sda_oe = (phase != Q3);
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            remaining  <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            sda_sample <= 1'b0;
            nack_err   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (accept) begin
                tx_shift  <= {cmd_addr, cmd_rw};
                rw_q      <= cmd_rw;
                wdata_q   <= cmd_wdata;
                remaining <= (cmd_len == '0) ? ONE : cmd_len;
                nack_err  <= 1'b0;
                bit_cnt   <= '0;
            end
            if (sample) begin
                sda_sample <= sda_i;
                if (state == ST_RDATA) rx_shift <= {rx_shift[6:0], sda_i};
            end
            if (bit_end) begin
                case (state)
                    ST_ADDR: begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        tx_shift <= (bit_cnt == 3'd7) ? wdata_q : {tx_shift[6:0], 1'b0};
                    end
                    ST_WDATA: begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    ST_RDATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rd_valid <= 1'b1;
                            rd_data  <= rx_shift;
                        end
                    end
                    ST_AACK, ST_WACK: if (sda_sample) nack_err <= 1'b1;
                    ST_MACK: if (remaining > ONE) remaining <= remaining - ONE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: wired-AND bus with a behavioural slave, table of
// transactions plus hand-written stretch, reset and handshake sequences.
module tb_i2c_master_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic [7:0] cmd_len = '0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       done;
    logic       nack_err;
    logic       busy;
    logic       scl_oe, sda_oe;
    logic       scl_line, sda_line;
    logic       slv_scl_pull = 1'b0;
    logic       slv_sda_pull = 1'b0;

    assign scl_line = ~(scl_oe | slv_scl_pull);
    assign sda_line = ~(sda_oe | slv_sda_pull);

    i2c_master_seq #(.CLK_DIV(4), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .nack_err  (nack_err),
        .busy      (busy),
        .scl_i     (scl_line),
        .sda_i     (sda_line),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: acks 0x30 and 0x50, serves a fixed read pattern.
    logic [7:0] rd_pattern [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       scl_prev = 1'b1, sda_prev = 1'b1, scl_now, sda_now;
    logic       s_active = 1'b0, s_read = 1'b0, s_acked = 1'b0;
    int         s_bit = 0, s_byte = 0, s_rises = 0, s_frames = 0;
    logic [7:0] s_sh = '0, s_tx = '0, s_addr_log = '0;
    logic [7:0] s_wlog [$];
    logic       s_mack_log [$];
    logic       stretch_en = 1'b0;
    int         stretch_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            slv_sda_pull = 1'b0;
            slv_scl_pull = 1'b0;
            s_active     = 1'b0;
            s_read       = 1'b0;
            scl_prev     = 1'b1;
            sda_prev     = 1'b1;
            s_bit        = 0;
            s_byte       = 0;
        end else begin
            scl_now = scl_line;
            sda_now = sda_line;
            if (scl_prev && scl_now && sda_prev && !sda_now) begin
                s_active = 1'b1; s_bit = 0; s_byte = 0; s_read = 1'b0; s_acked = 1'b0;
                s_rises = 0; s_frames++; s_addr_log = '0;
                s_wlog.delete(); s_mack_log.delete();
                slv_sda_pull = 1'b0;
            end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
                s_active = 1'b0;
                slv_sda_pull = 1'b0;
            end else if (s_active && !scl_prev && scl_now) begin
                s_rises++;
                if (s_bit < 8) s_sh = {s_sh[6:0], sda_now};
                else if (s_read && s_byte >= 1) s_mack_log.push_back(sda_now);
                s_bit++;
            end else if (s_active && scl_prev && !scl_now) begin
                if (s_bit == 8) begin
                    if (s_byte == 0) begin
                        s_addr_log   = s_sh;
                        s_acked      = (s_sh[7:1] == 7'h30) || (s_sh[7:1] == 7'h50);
                        s_read       = s_sh[0];
                        slv_sda_pull = s_acked;
                    end else if (!s_read) begin
                        s_wlog.push_back(s_sh);
                        slv_sda_pull = 1'b1;
                    end else begin
                        slv_sda_pull = 1'b0;
                    end
                end else if (s_bit == 9) begin
                    s_bit = 0;
                    s_byte++;
                    slv_sda_pull = 1'b0;
                    if (s_read && s_acked &&
                        (s_byte == 1 || (s_mack_log.size() > 0 && s_mack_log[$] == 1'b0))) begin
                        s_tx = rd_pattern[(s_byte - 1) % 4];
                        slv_sda_pull = !s_tx[7];
                    end
                end else if (s_read && s_acked && s_byte >= 1 && s_bit >= 1 && s_bit <= 7) begin
                    slv_sda_pull = !s_tx[7 - s_bit];
                end
                if (stretch_en && !s_read && s_byte == 1 && s_bit == 1) begin
                    slv_scl_pull = 1'b1;
                    stretch_cnt  = 0;
                    stretch_en   = 1'b0;
                end
            end
            if (slv_scl_pull && !scl_oe) begin
                if (stretch_cnt == 20) slv_scl_pull = 1'b0;
                else stretch_cnt++;
            end
            scl_prev = scl_now;
            sda_prev = sda_now;
        end
    end

    // Monitor and read-data scoreboard.
    logic [7:0] exp_rd_q [$];
    int   cyc = 0, busy_cnt = 0, rise_cyc = 0, done_cyc = 0, done_cnt = 0, rd_pops = 0;
    int   done_base = 0;
    logic busy_prev = 1'b0, done_nack = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (busy && !busy_prev) rise_cyc = cyc;
        busy_prev = busy;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_nack = nack_err;
        end
        if (rd_valid) begin
            rd_pops++;
            if (exp_rd_q.size() == 0) checkOutput("rd_unexpected", 1, 0);
            else checkOutput("rd_data", int'(rd_data), int'(exp_rd_q.pop_front()));
        end
    end

    task automatic applyStimulus(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                 input logic [7:0] len, input int npush);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_len = len; cmd_valid = 1'b1;
        busy_cnt  = 0;
        done_base = done_cnt;
        for (int i = 0; i < npush; i++) exp_rd_q.push_back(rd_pattern[i % 4]);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (done_cnt < target && n < 5000) begin @(negedge clk); #1; n++; end
        checkOutput("done_seen", (done_cnt >= target) ? 1 : 0, 1);
    endtask

    function automatic int mackCode();
        int v = 0;
        foreach (s_mack_log[i]) v = (v << 1) | int'(s_mack_log[i]);
        return v;
    endfunction

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic [7:0] len;
        logic       exp_nack;
        int         exp_bytes;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int first_done, frames0, pops0, dones0, n;
        vecs[0] = '{7'h30, 1'b0, 8'hCC, 8'd0, 1'b0, 1};
        vecs[1] = '{7'h50, 1'b1, 8'h00, 8'd4, 1'b0, 4};
        vecs[2] = '{7'h7F, 1'b0, 8'h55, 8'd0, 1'b1, 0};
        vecs[3] = '{7'h50, 1'b1, 8'h00, 8'd2, 1'b0, 2};
        vecs[4] = '{7'h7F, 1'b1, 8'h00, 8'd3, 1'b1, 0};
        vecs[5] = '{7'h50, 1'b0, 8'hA5, 8'd0, 1'b0, 1};

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_scl_oe", scl_oe, 0);
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_nack_err", nack_err, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        $display("[TB] table transactions");
        for (int i = 0; i < 6; i++) begin
            pops0 = rd_pops;
            applyStimulus(vecs[i].addr, vecs[i].rw, vecs[i].wdata, vecs[i].len,
                          vecs[i].rw ? vecs[i].exp_bytes : 0);
            waitDone(done_base + 1);
            checkOutput($sformatf("v%0d_nack", i), done_nack, vecs[i].exp_nack);
            checkOutput($sformatf("v%0d_busy_cycles", i), busy_cnt, (44 + 36 * vecs[i].exp_bytes) * 4);
            checkOutput($sformatf("v%0d_addr_byte", i), s_addr_log, {vecs[i].addr, vecs[i].rw});
            if (vecs[i].exp_nack) begin
                checkOutput($sformatf("v%0d_scl_rises", i), s_rises, 10);
                checkOutput($sformatf("v%0d_wbytes", i), s_wlog.size(), 0);
            end else if (!vecs[i].rw) begin
                checkOutput($sformatf("v%0d_wbytes", i), s_wlog.size(), 1);
                if (s_wlog.size() > 0) checkOutput($sformatf("v%0d_wdata", i), s_wlog[0], vecs[i].wdata);
            end else begin
                checkOutput($sformatf("v%0d_mack_count", i), s_mack_log.size(), vecs[i].exp_bytes);
                checkOutput($sformatf("v%0d_mack_code", i), mackCode(), 1);
            end
            checkOutput($sformatf("v%0d_rd_pulses", i), rd_pops - pops0, vecs[i].rw ? vecs[i].exp_bytes : 0);
        end

        $display("[TB] clock stretch");
        stretch_en = 1'b1;
        applyStimulus(7'h30, 1'b0, 8'hCC, 8'd0, 0);
        waitDone(done_base + 1);
        checkOutput("stretch_busy_cycles", busy_cnt, 320 + 20);
        checkOutput("stretch_nack", done_nack, 0);
        checkOutput("stretch_wbytes", s_wlog.size(), 1);
        if (s_wlog.size() > 0) checkOutput("stretch_wdata", s_wlog[0], 8'hCC);

        $display("[TB] reset mid-read");
        applyStimulus(7'h50, 1'b1, 8'h00, 8'd4, 0);
        n = 0;
        while (!(s_active && s_read && s_byte == 1 && s_bit == 3) && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("reset_reached_rdata", n < 3000 ? 1 : 0, 1);
        pops0  = rd_pops;
        dones0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_scl_oe", scl_oe, 0);
        checkOutput("midrst_sda_oe", sda_oe, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_cmd_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        checkOutput("midrst_no_rd_valid", rd_pops - pops0, 0);
        checkOutput("midrst_no_done", done_cnt - dones0, 0);

        $display("[TB] back-to-back handshake");
        @(negedge clk);
        frames0 = s_frames;
        pops0   = rd_pops;
        cmd_addr = 7'h30; cmd_rw = 1'b0; cmd_wdata = 8'hCC; cmd_len = 8'd0; cmd_valid = 1'b1;
        busy_cnt  = 0;
        done_base = done_cnt;
        @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = 1'b1; cmd_wdata = 8'h00; cmd_len = 8'd0;
        exp_rd_q.push_back(rd_pattern[0]);
        waitDone(done_base + 1);
        first_done = done_cyc;
        checkOutput("hs1_nack", done_nack, 0);
        checkOutput("hs1_busy_cycles", busy_cnt, 320);
        checkOutput("hs1_wdata", s_wlog.size() > 0 ? int'(s_wlog[0]) : -1, 8'hCC);
        n = 0;
        while (!busy && n < 100) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b0;
        busy_cnt  = 0;
        waitDone(done_base + 2);
        checkOutput("hs_accept_gap", rise_cyc - first_done, 2);
        checkOutput("hs2_nack", done_nack, 0);
        checkOutput("hs2_busy_cycles", busy_cnt, 320);
        checkOutput("hs2_addr_byte", s_addr_log, 8'hA1);
        checkOutput("hs2_mack_count", s_mack_log.size(), 1);
        checkOutput("hs2_mack_code", mackCode(), 1);
        checkOutput("hs2_rd_pulses", rd_pops - pops0, 1);
        checkOutput("hs_frames", s_frames - frames0, 2);

        $display("[TB] cmd_valid while busy");
        frames0 = s_frames;
        applyStimulus(7'h30, 1'b0, 8'hCC, 8'd0, 0);
        repeat (50) @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        waitDone(done_base + 1);
        checkOutput("ign_busy_cycles", busy_cnt, 320);
        checkOutput("ign_wdata", s_wlog.size() > 0 ? int'(s_wlog[0]) : -1, 8'hCC);
        busy_cnt = 0;
        repeat (40) @(negedge clk);
        #1;
        checkOutput("ign_no_second_cmd", busy_cnt, 0);
        checkOutput("ign_frames", s_frames - frames0, 1);

        checkOutput("sb_empty", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Command-driven I2C master that sequences complete bus transactions on the two-wire bus used by the i2c slave.
- Transaction types: single-byte register write, and burst read of N bytes.
- Sits between the system/config logic and the open-drain SDA/SCL pads.
- Generates START, address, data, ACK/NACK and STOP, and reports received bytes and errors.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL bit period. Range 4 to 65535.
- LEN_W, 8: width of the read byte count.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high in IDLE only; command accepted when cmd_valid && cmd_ready
- cmd_addr  input  7  7-bit slave address
- cmd_rw  input  1  0 = write, 1 = read
- cmd_wdata  input  8  write byte (write command)
- cmd_len  input  LEN_W  bytes to read (read command); 0 is treated as 1
- rd_valid  output  1  one-cycle pulse per received byte
- rd_data  output  8  received byte, valid with rd_valid, held until next byte
- done  output  1  one-cycle pulse after STOP completes
- nack_err  output  1  valid with done; 1 = slave NACKed address or write data
- busy  output  1  high from command accept until done
- scl_i  input  1  SCL pad level (used for clock stretching)
- sda_i  input  1  SDA pad level
- scl_oe  output  1  1 = pull SCL low, 0 = release
- sda_oe  output  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; scl_oe = 0, sda_oe = 0 (bus released).
  - cmd_ready = 1; busy, rd_valid, done, nack_err = 0; rd_data = 0; all counters 0.
  - A reset mid-transaction releases the bus with no STOP generated.
- Timebase:
  - A quarter-tick counter runs only when not IDLE.
  - Each bit uses 4 phases q0..q3. SCL is low in q0-q1 and released in q2-q3.
  - SDA changes only at the q0 entry. SDA is sampled at q2 -> q3.
- Clock stretching: in q2, if scl_oe = 0 and scl_i = 0, the quarter counter holds until scl_i = 1.
- Command accept: cmd_addr, cmd_rw, cmd_wdata and cmd_len are latched. Next cycle: busy = 1, cmd_ready = 0.
- State sequence:
  - IDLE -> START: 4 quarters. Both released for q0-q1; sda_oe = 1 at q2; scl_oe = 1 at q3.
  - START -> ADDR: 8 bits of {addr, rw}, MSB first.
  - ADDR -> AACK: SDA released; sample at q2.
  - AACK:
    - Sample 1 -> nack_err = 1, go to STOP.
    - Sample 0 -> WDATA if write, RDATA if read.
  - WDATA -> WACK: 8 bits of cmd_wdata, MSB first.
  - WACK: SDA released. NACK sets nack_err. Always go to STOP.
  - RDATA: SDA released; sample 8 bits, MSB first. After bit 0, pulse rd_valid for 1 cycle with rd_data.
  - MACK:
    - Remaining count > 1 -> sda_oe = 1 (ACK), decrement, go to RDATA.
    - Otherwise sda_oe = 0 (NACK), go to STOP.
  - STOP: 4 quarters. sda_oe = 1 with SCL low (q0-q1); release SCL at q2; release SDA at q3.
  - STOP -> DONE: done pulses 1 cycle with nack_err valid; busy = 0; return to IDLE; cmd_ready = 1 the following cycle.
- Command timing:
  - A back-to-back command may be accepted the cycle after done.
  - cmd_valid while busy is ignored and not queued.
- Arithmetic: remaining count is a LEN_W-bit down-counter loaded with max(cmd_len, 1). No wrap.
- nack_err is cleared on command accept.

Decomposition:
- Package i2c_pkg:
  - State enum.
  - Constants RW_WRITE = 0, RW_READ = 1.
  - Phase encoding Q0..Q3.
- Sub-module i2c_qtick: quarter-tick generator with hold (stretch) input. Emits a 1-cycle tick every CLK_DIV cycles while enabled.
- All other logic (FSM, shift register, bit counter, byte counter) lives in the top module.

Test Plan (CLK_DIV = 4, open-drain pads modelled as wired-AND with pull-ups, bench slave model):
- Write addr 0x30, data 0xCC, slave ACKs both:
  - SDA bits after START = 0x60, ACK, 0xCC, ACK, then STOP.
  - done = 1, nack_err = 0.
  - Exactly 4 + 9*4 + 9*4 + 4 quarters of bus activity.
- Read addr 0x50, len 4, slave returns 0x11, 0x22, 0x33, 0x44:
  - Address byte 0xA1.
  - 4 rd_valid pulses with those values in order.
  - Master ACK after the first 3 bytes, NACK after the 4th.
  - STOP, then done with nack_err = 0.
- Address NACK (no slave at 0x7F):
  - nack_err = 1 with done.
  - No data bits clocked.
  - STOP follows the ACK bit directly.
- Clock stretching: slave holds SCL low 20 cycles in the 2nd bit of the write data. That bit's high phase is delayed by exactly 20 cycles, and the received data is still 0xCC.
- Reset mid-transaction: rst asserted during RDATA bit 3.
  - Same cycle: scl_oe = sda_oe = 0, busy = 0, cmd_ready = 1.
  - No rd_valid or done pulse.
- Handshake: cmd_valid held high across a completing command.
  - Second command is accepted only after done, and cmd_len = 0 reads exactly 1 byte with NACK.
  - cmd_valid pulses while busy produce no effect.
